// File: rtl/occupancy_map_reader.sv
// Streams every occupancy grid cell, in address order, onto a valid/ready stream.
// Define OCCUPANCY_READER_CHECKSUM_EN to append a mod-2^DATA_WIDTH checksum word after the grid.
module occupancy_map_reader #(
  parameter int MAP_SIZE   = 32768,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAP_SIZE - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]   hold_addr_q, hold_addr_d;
  logic [ADDR_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic                    inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   fifo_q [2];
  logic [DATA_WIDTH-1:0]   fifo_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    fifo_valid;
  logic                    push;
  logic                    pop;
  logic                    word_last;
  logic                    final_hs;
  logic [1:0]              credits;

`ifdef OCCUPANCY_READER_CHECKSUM_EN
  logic                    cks_valid_q, cks_valid_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
`endif

  // Stream side: FIFO head, or the checksum word once the grid has drained.
  always_comb begin
    fifo_valid = (count_q != 2'd0);
    word_last  = (out_cnt_q == LAST_ADDR);
    pop        = fifo_valid && out_ready;
    push       = inflight_q;
`ifdef OCCUPANCY_READER_CHECKSUM_EN
    out_valid  = fifo_valid || cks_valid_q;
    out_data   = cks_valid_q ? sum_q : fifo_q[rd_ptr_q];
    out_last   = cks_valid_q;
    final_hs   = cks_valid_q && out_ready;
`else
    out_valid  = fifo_valid;
    out_data   = fifo_q[rd_ptr_q];
    out_last   = fifo_valid && word_last;
    final_hs   = pop && word_last;
`endif
  end

  // Words held after this cycle's pop plus the read in flight must leave room for one more.
  always_comb begin
    credits         = count_q - 2'(pop) + 2'(inflight_q);
    mem_read_enable = (state_q == READ) && (credits < 2'd2);
    mem_addr        = mem_read_enable ? rd_addr_q : hold_addr_q;
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    hold_addr_d = hold_addr_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = mem_read_enable;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + 2'(push) - 2'(pop);
    busy        = 1'b0;
    done        = 1'b0;
`ifdef OCCUPANCY_READER_CHECKSUM_EN
    cks_valid_d = cks_valid_q;
    sum_d       = sum_q;
    if (pop) begin
      sum_d = sum_q + fifo_q[rd_ptr_q];
    end
    if (pop && word_last) begin
      cks_valid_d = 1'b1;
    end
    if (final_hs) begin
      cks_valid_d = 1'b0;
    end
`endif

    if (push) begin
      fifo_d[wr_ptr_q] = mem_read_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (!word_last) begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
    if (mem_read_enable) begin
      hold_addr_d = rd_addr_q;
      if (rd_addr_q != LAST_ADDR) begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          rd_addr_d = '0;
          out_cnt_d = '0;
`ifdef OCCUPANCY_READER_CHECKSUM_EN
          sum_d       = '0;
          cks_valid_d = 1'b0;
`endif
        end
      end
      READ: begin
        busy = 1'b1;
        if (mem_read_enable && (rd_addr_q == LAST_ADDR)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (final_hs) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      hold_addr_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
`ifdef OCCUPANCY_READER_CHECKSUM_EN
      cks_valid_q <= 1'b0;
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      hold_addr_q <= hold_addr_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
`ifdef OCCUPANCY_READER_CHECKSUM_EN
      cks_valid_q <= cks_valid_d;
      sum_q       <= sum_d;
`endif
    end
  end

endmodule
